// File: rtl/ram_arb_pkg.sv
// Shared types for the data-RAM arbiter: owner state encoding and port indices.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } owner_t;

    localparam int PORT0 = 0;
    localparam int PORT1 = 1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way combinational picker: round-robin on last grant, or fixed priority to port 0.
module rr_pick2
    import ram_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_lastGnt,
    input  logic       i_fixed,
    output logic [1:0] o_gnt
);

    // On a tie the port that did not win last time goes next, unless port 0 is pinned.
    always_comb begin
        o_gnt = 2'b00;
        if (i_req == 2'b11) begin
            if (i_fixed || i_lastGnt) begin
                o_gnt[PORT0] = 1'b1;
            end else begin
                o_gnt[PORT1] = 1'b1;
            end
        end else begin
            o_gnt = i_req;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port data RAM between the CPU data port (0) and the sprite engine (1),
// with zero-latency grants, a one-cycle read-valid strobe and per-port lock bursts.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 12,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0,
    input  logic                     req1,
    input  logic                     we0,
    input  logic                     we1,
    input  logic [ADDRESS_WIDTH-1:0] addr0,
    input  logic [ADDRESS_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0]    wdata0,
    input  logic [DATA_WIDTH-1:0]    wdata1,
    input  logic                     lock0,
    input  logic                     lock1,
    output logic                     gnt0,
    output logic                     gnt1,
    output logic                     rvalid0,
    output logic                     rvalid1,
    output logic [DATA_WIDTH-1:0]    rdata0,
    output logic [DATA_WIDTH-1:0]    rdata1,
    output logic                     ram_wEn,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]    ram_dataIn,
    input  logic [DATA_WIDTH-1:0]    ram_dataOut
);

    localparam logic C_FIXED = (FIXED_PRIORITY != 0);

    owner_t     r_state;
    owner_t     w_stateNext;
    logic       r_lastGnt;
    logic       r_rvalid0;
    logic       r_rvalid1;
    logic [1:0] w_reqEff;
    logic [1:0] w_pick;
    logic [1:0] w_gnt;

    // A lock owner hides the other port's request from the picker entirely.
    always_comb begin
        w_reqEff = 2'b00;
        case (r_state)
            FREE:    w_reqEff = {req1, req0};
            LOCK0:   w_reqEff = {1'b0, req0};
            LOCK1:   w_reqEff = {req1, 1'b0};
            default: w_reqEff = 2'b00;
        endcase
    end

    rr_pick2 u_pick (
        .i_req     (w_reqEff),
        .i_lastGnt (r_lastGnt),
        .i_fixed   (C_FIXED),
        .o_gnt     (w_pick)
    );

    assign w_gnt = reset ? 2'b00 : w_pick;
    assign gnt0  = w_gnt[PORT0];
    assign gnt1  = w_gnt[PORT1];

    always_comb begin
        ram_wEn    = 1'b0;
        ram_addr   = '0;
        ram_dataIn = '0;
        if (w_gnt[PORT0]) begin
            ram_wEn    = we0;
            ram_addr   = addr0;
            ram_dataIn = wdata0;
        end else if (w_gnt[PORT1]) begin
            ram_wEn    = we1;
            ram_addr   = addr1;
            ram_dataIn = wdata1;
        end
    end

    // A lock is released by the owner dropping its lock bit, whether or not it was granted.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            FREE: begin
                if (w_gnt[PORT0] && lock0) begin
                    w_stateNext = LOCK0;
                end else if (w_gnt[PORT1] && lock1) begin
                    w_stateNext = LOCK1;
                end
            end
            LOCK0:   if (!lock0) w_stateNext = FREE;
            LOCK1:   if (!lock1) w_stateNext = FREE;
            default: w_stateNext = FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= FREE;
            r_lastGnt <= 1'b1;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            if (|w_gnt) begin
                r_lastGnt <= w_gnt[PORT1];
            end
            r_rvalid0 <= w_gnt[PORT0] & ~we0;
            r_rvalid1 <= w_gnt[PORT1] & ~we1;
        end
    end

    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign rdata0  = ram_dataOut;
    assign rdata1  = ram_dataOut;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a round-robin and a fixed-priority instance share stimulus,
// each backed by its own RAM, and are checked against a port-level reference model.
module tb_ram_arbiter;

    localparam int DW = 32;
    localparam int AW = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, req0, req1, we0, we1, lock0, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;

    logic          gnt0 [2];
    logic          gnt1 [2];
    logic          rvalid0 [2];
    logic          rvalid1 [2];
    logic          ramWEn [2];
    logic [AW-1:0] ramAddr [2];
    logic [DW-1:0] ramDataIn [2];
    logic [DW-1:0] ramDataOut [2];
    logic [DW-1:0] rdata0 [2];
    logic [DW-1:0] rdata1 [2];

    logic [DW-1:0] ramMem [2][4096];
    logic [DW-1:0] refMem [2][4096];
    logic          preEn;
    logic [AW-1:0] preAddr;
    logic [DW-1:0] preData;

    int            checks = 0;
    int            fails  = 0;

    // Reference model per instance (0 = round-robin, 1 = fixed priority):
    // owner is -1 when free, else the locked port; rv is the port expecting read data.
    int            mOwner [2];
    int            mLast [2];
    int            mRv [2];
    logic [DW-1:0] mRd [2];

    ram_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FIXED_PRIORITY(0)) dutRr (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .lock0(lock0), .lock1(lock1),
        .gnt0(gnt0[0]), .gnt1(gnt1[0]), .rvalid0(rvalid0[0]), .rvalid1(rvalid1[0]),
        .rdata0(rdata0[0]), .rdata1(rdata1[0]),
        .ram_wEn(ramWEn[0]), .ram_addr(ramAddr[0]), .ram_dataIn(ramDataIn[0]),
        .ram_dataOut(ramDataOut[0])
    );

    ram_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FIXED_PRIORITY(1)) dutFp (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .lock0(lock0), .lock1(lock1),
        .gnt0(gnt0[1]), .gnt1(gnt1[1]), .rvalid0(rvalid0[1]), .rvalid1(rvalid1[1]),
        .rdata0(rdata0[1]), .rdata1(rdata1[1]),
        .ram_wEn(ramWEn[1]), .ram_addr(ramAddr[1]), .ram_dataIn(ramDataIn[1]),
        .ram_dataOut(ramDataOut[1])
    );

    // Single-port RAMs: write on wEn, otherwise register the addressed word.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (preEn) ramMem[d][preAddr] <= preData;
            else if (ramWEn[d]) ramMem[d][ramAddr[d]] <= ramDataIn[d];
            else ramDataOut[d] <= ramMem[d][ramAddr[d]];
        end
    end

    function automatic int expGnt(int d);
        if (reset) return -1;
        if (mOwner[d] == 0) return req0 ? 0 : -1;
        if (mOwner[d] == 1) return req1 ? 1 : -1;
        if (req0 && req1) return (d == 1) ? 0 : 1 - mLast[d];
        if (req0) return 0;
        if (req1) return 1;
        return -1;
    endfunction

    function automatic logic [3:0] expFlags(int d);
        int g;
        g = expGnt(d);
        return {g == 1, g == 0, mRv[d] == 1, mRv[d] == 0};
    endfunction

    function automatic logic [3:0] obsFlags(int d);
        return {gnt1[d], gnt0[d], rvalid1[d], rvalid0[d]};
    endfunction

    function automatic logic [44:0] expBus(int d);
        int g;
        g = expGnt(d);
        if (g == 0) return {we0, addr0, wdata0};
        if (g == 1) return {we1, addr1, wdata1};
        return '0;
    endfunction

    function automatic logic [44:0] obsBus(int d);
        return {ramWEn[d], ramAddr[d], ramDataIn[d]};
    endfunction

    function automatic logic [DW-1:0] obsRdata(int d);
        return (mRv[d] == 1) ? rdata1[d] : rdata0[d];
    endfunction

    // Advance the model across the coming posedge, then step the clock.
    task automatic tick();
        for (int d = 0; d < 2; d++) begin
            int            g;
            logic          w;
            logic [AW-1:0] a;
            logic [DW-1:0] wd;
            logic          lk;
            g = expGnt(d);
            w = 1'b0; a = '0; wd = '0; lk = 1'b0;
            if (g == 0) begin w = we0; a = addr0; wd = wdata0; lk = lock0; end
            if (g == 1) begin w = we1; a = addr1; wd = wdata1; lk = lock1; end
            if (reset) begin
                mOwner[d] = -1; mLast[d] = 1; mRv[d] = -1;
            end else begin
                mRv[d] = (g >= 0 && !w) ? g : -1;
                if (g >= 0 && !w) mRd[d] = refMem[d][a];
                if (g >= 0 && w) refMem[d][a] = wd;
                if (mOwner[d] < 0) begin
                    if (g >= 0 && lk) mOwner[d] = g;
                end else if (!((mOwner[d] == 0) ? lock0 : lock1)) begin
                    mOwner[d] = -1;
                end
                if (g >= 0) mLast[d] = g;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic resetPulse();
        idleInputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; req0 = 1; req1 = 1; we0 = 0; we1 = 1;
        addr0 = 12'h020; addr1 = 12'h021;
        #2;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obsFlags(d) !== 4'b0000)
                $display("[TB] FAIL reset_gnt dut%0d: got %b expected 0000", d, obsFlags(d));
            checks++;
            if (obsBus(d) !== 45'd0)
                $display("[TB] FAIL reset_bus dut%0d: got %h expected 0", d, obsBus(d));
        end
        if (obsFlags(0) !== 4'b0000 || obsBus(0) !== 45'd0) fails++;
        if (obsFlags(1) !== 4'b0000 || obsBus(1) !== 45'd0) fails++;
        tick();
        reset = 0;
        idleInputs();
        #2;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obsFlags(d) !== 4'b0000) begin
                fails++;
                $display("[TB] FAIL post_reset_idle dut%0d: got %b expected 0000", d, obsFlags(d));
            end
        end
        tick();
    endtask

    task automatic test_single_read();
        req0 = 1; we0 = 0; addr0 = 12'h010;
        #2;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obsFlags(d) !== 4'b0100 || ramAddr[d] !== 12'h010 || ramWEn[d] !== 1'b0) begin
                fails++;
                $display("[TB] FAIL single_read_gnt dut%0d: got flags %b addr %h expected 0100 010",
                         d, obsFlags(d), ramAddr[d]);
            end
        end
        tick();
        idleInputs();
        #2;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obsFlags(d) !== 4'b0001 || rdata0[d] !== 32'hDEADBEEF) begin
                fails++;
                $display("[TB] FAIL single_read_data dut%0d: got flags %b data %h expected 0001 deadbeef",
                         d, obsFlags(d), rdata0[d]);
            end
        end
        tick();
    endtask

    task automatic test_contention();
        resetPulse();
        for (int c = 0; c < 6; c++) begin
            req0 = (c < 4); req1 = (c < 5); we0 = 0; we1 = 0;
            addr0 = AW'($urandom_range(0, 63));
            addr1 = AW'($urandom_range(0, 63));
            #2;
            if (c < 4) begin
                checks++;
                if ({gnt1[0], gnt0[0]} !== ((c % 2 == 1) ? 2'b10 : 2'b01)) begin
                    fails++;
                    $display("[TB] FAIL rr_sequence cycle%0d: got %b%b", c, gnt1[0], gnt0[0]);
                end
                checks++;
                if ({gnt1[1], gnt0[1]} !== 2'b01) begin
                    fails++;
                    $display("[TB] FAIL fp_port0_wins cycle%0d: got %b%b expected 01", c, gnt1[1], gnt0[1]);
                end
            end else if (c == 4) begin
                checks++;
                if ({gnt1[1], gnt0[1]} !== 2'b10) begin
                    fails++;
                    $display("[TB] FAIL fp_port1_after_drop: got %b%b expected 10", gnt1[1], gnt0[1]);
                end
            end
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obsFlags(d) !== expFlags(d)) begin
                    fails++;
                    $display("[TB] FAIL contention_flags dut%0d cycle%0d: got %b expected %b",
                             d, c, obsFlags(d), expFlags(d));
                end
                if (mRv[d] >= 0) begin
                    checks++;
                    if (obsRdata(d) !== mRd[d]) begin
                        fails++;
                        $display("[TB] FAIL contention_rdata dut%0d cycle%0d: got %h expected %h",
                                 d, c, obsRdata(d), mRd[d]);
                    end
                end
            end
            tick();
        end
    endtask

    task automatic test_lock_burst();
        resetPulse();
        for (int k = 0; k < 5; k++) begin
            req0 = (k >= 1); we0 = 0; addr0 = AW'($urandom_range(0, 63));
            req1 = (k < 4); we1 = 1; lock1 = (k < 3);
            addr1 = AW'($urandom_range(0, 63)); wdata1 = $urandom;
            #2;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if ({gnt1[d], gnt0[d]} !== ((k < 4) ? 2'b10 : 2'b01)) begin
                    fails++;
                    $display("[TB] FAIL lock_burst_gnt dut%0d step%0d: got %b%b expected %s",
                             d, k, gnt1[d], gnt0[d], (k < 4) ? "10" : "01");
                end
                checks++;
                if (obsBus(d) !== expBus(d)) begin
                    fails++;
                    $display("[TB] FAIL lock_burst_bus dut%0d step%0d: got %h expected %h",
                             d, k, obsBus(d), expBus(d));
                end
            end
            tick();
        end
        idleInputs();
        tick();
    endtask

    task automatic test_wrap();
        req0 = 1; we0 = 1; addr0 = 12'hFFF; wdata0 = 32'h12345678;
        #2;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obsBus(d) !== {1'b1, 12'hFFF, 32'h12345678}) begin
                fails++;
                $display("[TB] FAIL top_write_bus dut%0d: got %h", d, obsBus(d));
            end
        end
        tick();
        idleInputs();
        req1 = 1; we1 = 0; addr1 = 12'hFFF;
        #2;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obsFlags(d) !== 4'b1000) begin
                fails++;
                $display("[TB] FAIL top_read_gnt dut%0d: got %b expected 1000", d, obsFlags(d));
            end
        end
        tick();
        idleInputs();
        #2;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obsFlags(d) !== 4'b0010 || rdata1[d] !== 32'h12345678) begin
                fails++;
                $display("[TB] FAIL top_read_data dut%0d: got %b %h expected 0010 12345678",
                         d, obsFlags(d), rdata1[d]);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid_op();
        req0 = 1; we0 = 0; lock0 = 1; addr0 = AW'($urandom_range(0, 63));
        tick();
        reset = 1;
        #2;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (gnt0[d] !== 1'b0) begin
                fails++;
                $display("[TB] FAIL reset_forces_gnt dut%0d: got %b expected 0", d, gnt0[d]);
            end
        end
        tick();
        reset = 0; req0 = 0; lock0 = 0;
        req1 = 1; we1 = 0; addr1 = AW'($urandom_range(0, 63));
        #2;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obsFlags(d) !== 4'b1000) begin
                fails++;
                $display("[TB] FAIL reset_drops_lock dut%0d: got %b expected 1000", d, obsFlags(d));
            end
        end
        tick();
        idleInputs();
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset  = ($urandom_range(0, 49) == 0);
            req0   = ($urandom_range(0, 9) < 7);
            req1   = ($urandom_range(0, 9) < 7);
            we0    = $urandom_range(0, 1) == 1;
            we1    = $urandom_range(0, 1) == 1;
            lock0  = ($urandom_range(0, 3) == 0);
            lock1  = ($urandom_range(0, 3) == 0);
            addr0  = AW'($urandom_range(0, 63));
            addr1  = AW'($urandom_range(0, 63));
            wdata0 = $urandom;
            wdata1 = $urandom;
            #2;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obsFlags(d) !== expFlags(d)) begin
                    fails++;
                    $display("[TB] FAIL random_flags dut%0d cycle%0d: got %b expected %b",
                             d, c, obsFlags(d), expFlags(d));
                end
                checks++;
                if (obsBus(d) !== expBus(d)) begin
                    fails++;
                    $display("[TB] FAIL random_bus dut%0d cycle%0d: got %h expected %h",
                             d, c, obsBus(d), expBus(d));
                end
                if (mRv[d] >= 0) begin
                    checks++;
                    if (obsRdata(d) !== mRd[d]) begin
                        fails++;
                        $display("[TB] FAIL random_rdata dut%0d cycle%0d: got %h expected %h",
                                 d, c, obsRdata(d), mRd[d]);
                    end
                end
            end
            tick();
        end
        reset = 0;
        idleInputs();
        tick();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            mOwner[d] = -1; mLast[d] = 1; mRv[d] = -1; mRd[d] = '0;
        end
        idleInputs();
        reset = 1;
        preEn = 1;
        for (int i = 0; i < 65; i++) begin
            preAddr = (i == 64) ? 12'hFFF : AW'(i);
            preData = (i == 16) ? 32'hDEADBEEF : $urandom;
            refMem[0][preAddr] = preData;
            refMem[1][preAddr] = preData;
            tick();
        end
        preEn = 0;

        test_reset();
        test_single_read();
        test_contention();
        test_lock_burst();
        test_wrap();
        test_reset_mid_op();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single-port data RAM between the processor data port (port 0) and the game/sprite engine (port 1). Each cycle the arbiter grants at most one requester. It drives the RAM write-enable, address and write-data inputs from the granted port and routes the RAM read data back with a one-cycle-later valid strobe. It supports round-robin or fixed-priority selection and a per-port lock for uninterrupted bursts.

## Interface
- DATA_WIDTH, 32, RAM word width
- ADDRESS_WIDTH, 12, RAM word-address width
- FIXED_PRIORITY, 0, 0 = round-robin; 1 = port 0 always wins contention
- clk  input  1  single system clock; all state updates on posedge
- reset  input  1  synchronous, active-high
- req0 / req1  input  1  access request; held with its command until granted
- we0 / we1  input  1  1 = write, 0 = read
- addr0 / addr1  input  ADDRESS_WIDTH  word address
- wdata0 / wdata1  input  DATA_WIDTH  write data
- lock0 / lock1  input  1  keep ownership after this grant
- gnt0 / gnt1  output  1  combinational; command accepted this cycle
- rvalid0 / rvalid1  output  1  registered; read data valid this cycle
- rdata0 / rdata1  output  DATA_WIDTH  ram_dataOut, valid only with matching rvalid
- ram_wEn  output  1  to RAM wEn
- ram_addr  output  ADDRESS_WIDTH  to RAM addr
- ram_dataIn  output  DATA_WIDTH  to RAM dataIn
- ram_dataOut  input  DATA_WIDTH  from RAM dataOut; updates only on non-write cycles, one cycle after the address

## Operation
- Owner FSM states: FREE, LOCK0, LOCK1. Reset state is FREE.
  - FREE: resolve contention as below. A grant to port N with lockN=1 moves the FSM to LOCKN.
  - LOCKN: only port N may be granted; the other port's gnt is 0 regardless of its req.
  - LOCKN exits to FREE at the posedge after a cycle in which lockN=0. This covers both "granted with lockN=0" and "idle with lockN=0".
- Round-robin (FIXED_PRIORITY=0):
  - 1-bit last_gnt register, reset to 1, so port 0 wins the first tie.
  - On contention in FREE, the port that is not last_gnt wins.
  - last_gnt updates on every grant.
- Fixed priority (FIXED_PRIORITY=1): port 0 wins every contention in FREE. last_gnt is still maintained but ignored.
- Single requester in FREE: granted the same cycle.
- RAM drive:
  - When gntN=1, ram_addr=addrN, ram_dataIn=wdataN, ram_wEn=weN.
  - With no grant: ram_wEn=0, ram_addr=0, ram_dataIn=0.
- Read return: a granted read (weN=0) sets rvalidN at the next posedge for exactly one cycle. rdataN = ram_dataOut during that cycle.
- Granted writes produce no rvalid.
- rdata0/rdata1 are always wired to ram_dataOut. Requesters must qualify them with rvalid.

## Timing
- Grant latency: 0 cycles. gnt is combinational from req, FSM state and last_gnt.
- Read latency: 1 cycle from grant to rvalid. Throughput is one access per cycle, reads and writes freely interleaved.
- Write then read of the same address on consecutive cycles returns the new data.
- After a write grant, ram_dataOut holds its previous value. Nothing consumes it because no rvalid is raised.
- At most one of gnt0/gnt1 and at most one of rvalid0/rvalid1 is high in any cycle.
- Reset values: FSM=FREE, last_gnt=1, rvalid0=rvalid1=0.
- gnt/ram_* outputs are combinational and force to 0 while reset=1.
- Reset mid-operation: a read granted in the cycle reset is asserted produces no rvalid. An active lock is dropped.
- Starvation bound in FREE, round-robin: a continuously requesting port is granted within 2 cycles. A locked owner can block the other port indefinitely; this is by design.

## Structure
- Shared package `ram_arb_pkg`:
  - owner state encoding (FREE=2'd0, LOCK0=2'd1, LOCK1=2'd2)
  - port index constants
- One sub-module `rr_pick2`: combinational 2-way picker. Inputs: req vector, last_gnt, fixed-priority flag. Output: one-hot grant.
- FSM, last_gnt register and rvalid pipeline live in ram_arbiter.
- The RAM itself is instantiated by the parent, not inside this block.

## Test plan
- Reset, then req0 read addr 0x010 with RAM preloaded 0xDEADBEEF:
  - gnt0=1 in the same cycle
  - next cycle rvalid0=1, rdata0=0xDEADBEEF; rvalid1=0.
- req0 and req1 both held for 4 cycles, round-robin:
  - grant sequence 0,1,0,1
  - each read returns on the matching rvalid only.
- Same contention with FIXED_PRIORITY=1: gnt0 for all 4 cycles; gnt1 only when req0 drops.
- Lock burst:
  - port 1 issues 3 writes with lock1=1, then a 4th with lock1=0, while req0 is held
  - gnt0=0 throughout the burst
  - gnt0=1 the cycle after the 4th grant.
- Port 0 writes 0x12345678 to 0xFFF; next cycle port 1 reads 0xFFF → rvalid1 with rdata1=0x12345678, wrapping at the top address.
- Reset asserted the cycle a port 0 read is granted, with lock0=1 → no rvalid0 afterwards, FSM=FREE, port 1 granted on its first request after reset.
